// File: rtl/img_row_loader.sv
// rtl/img_row_loader.sv - packs a raster pixel stream into full image rows and writes each row to the image SRAM
module img_row_loader #(
   parameter int PIX_W    = 8,
   parameter int COLS     = 640,
   parameter int ROWS     = 480,
   parameter int BEAT_PIX = 4,
   parameter int ADDR_W   = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [BEAT_PIX*PIX_W-1:0] s_data,
   input  logic                      s_last,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [COLS*PIX_W-1:0]     mem_din
);

   localparam int BEATS  = COLS / BEAT_PIX;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BW     = BEAT_PIX * PIX_W;
   localparam int ROW_W  = COLS * PIX_W;
   localparam int IDX_W  = (ROW_W > 1) ? $clog2(ROW_W) : 1;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]        state;
   logic [BEAT_W-1:0] beat;
   logic [ADDR_W-1:0] row;
   logic [ROW_W-1:0]  asm_row;
   logic [ROW_W-1:0]  row_next;
   logic [IDX_W-1:0]  lsb;
   logic              accept;
   logic              final_beat;

   assign s_ready    = (state == LOAD);
   assign busy       = (state == LOAD) || (state == FLUSH);
   assign done       = (state == DONE);
   assign accept     = s_valid & s_ready;
   assign final_beat = (beat == LAST_BEAT);
   assign lsb        = IDX_W'(beat) * IDX_W'(BW);

   // assembly row with the current beat merged in, so a completing row goes to mem_din without a stall
   always_comb begin
      row_next = asm_row;
      row_next[lsb +: BW] = s_data;
   end

   // frame sequencing, beat/row counting, framing check and row writes
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         beat     <= '0;
         row      <= '0;
         err      <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         asm_row  <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  beat  <= '0;
                  row   <= '0;
                  err   <= 1'b0;
               end
            end
            LOAD: begin
               if (accept) begin
                  asm_row <= row_next;
                  // row boundaries come from the beat count; s_last only flags disagreement
                  if (s_last != final_beat) begin
                     err <= 1'b1;
                  end
                  if (final_beat) begin
                     beat     <= '0;
                     mem_we   <= 1'b1;
                     mem_addr <= row;
                     mem_din  <= row_next;
                     if (row == LAST_ROW) begin
                        state <= FLUSH;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            FLUSH: state <= DONE;
            DONE:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_img_row_loader.sv
// tb/tb_img_row_loader.sv - bench for img_row_loader: small-frame model check plus one full-size frame
module tb_img_row_loader;

   localparam int SC = 8;
   localparam int SR = 3;
   localparam int SB = 4;
   localparam int SBEATS = SC / SB;
   localparam int DR = 480;
   localparam int DC = 640;
   localparam int DBEATS = 160;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // small configuration DUT
   logic        rst, start, s_valid, s_last;
   logic [31:0] s_data;
   logic        busy, done, err, s_ready, mem_we;
   logic [8:0]  mem_addr;
   logic [63:0] mem_din;

   img_row_loader #(.PIX_W(8), .COLS(SC), .ROWS(SR), .BEAT_PIX(SB), .ADDR_W(9)) u_small (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din)
   );

   // default configuration DUT
   logic          d_rst, d_start, d_valid, d_last;
   logic [31:0]   d_data;
   logic          d_busy, d_done, d_err, d_ready, d_we;
   logic [8:0]    d_addr;
   logic [5119:0] d_din;

   img_row_loader u_full (
      .clk(clk), .rst(d_rst), .start(d_start), .busy(d_busy), .done(d_done), .err(d_err),
      .s_valid(d_valid), .s_ready(d_ready), .s_data(d_data), .s_last(d_last),
      .mem_we(d_we), .mem_addr(d_addr), .mem_din(d_din)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] dpix(input int r, input int c);
      return 8'((r * 3 + c * 5) & 255);
   endfunction

   function automatic logic [5119:0] drow(input int r);
      logic [5119:0] v;
      for (int c = 0; c < DC; c++) v[8*c +: 8] = dpix(r, c);
      return v;
   endfunction

   // ---------------- small-config behavioural model ----------------
   bit          m_on = 1'b0;
   bit          m_loading, m_err;
   int          m_stage, m_k, m_b, m_r;
   logic [7:0]  m_row [SC];
   logic        e_we;
   logic [8:0]  e_addr;
   logic [63:0] e_din;

   // model: frame-level view in terms of the global accepted-beat index
   always @(posedge clk) begin
      e_we = 1'b0;
      if (rst) begin
         m_on = 1'b1; m_loading = 1'b0; m_stage = 0; m_err = 1'b0; m_k = 0;
         e_addr = '0; e_din = '0;
      end else if (m_on) begin
         if (m_loading && s_valid) begin
            m_b = m_k % SBEATS;
            m_r = m_k / SBEATS;
            for (int i = 0; i < SB; i++) m_row[m_b*SB + i] = s_data[8*i +: 8];
            if (s_last != (m_b == SBEATS - 1)) m_err = 1'b1;
            if (m_b == SBEATS - 1) begin
               e_we = 1'b1;
               e_addr = 9'(m_r);
               for (int c = 0; c < SC; c++) e_din[8*c +: 8] = m_row[c];
               if (m_r == SR - 1) begin
                  m_loading = 1'b0;
                  m_stage = 1;
               end
            end
            m_k++;
         end else if (m_stage == 1) begin
            m_stage = 2;
         end else if (m_stage == 2) begin
            m_stage = 0;
         end else if (!m_loading && start) begin
            m_loading = 1'b1; m_err = 1'b0; m_k = 0;
         end
      end
   end

   // per-cycle comparison of the small DUT against the model
   always @(negedge clk) begin
      if (m_on) begin
         chk("s_ready",  64'(s_ready),  64'(m_loading));
         chk("busy",     64'(busy),     64'(m_loading || m_stage == 1));
         chk("done",     64'(done),     64'(m_stage == 2));
         chk("err",      64'(err),      64'(m_err));
         chk("mem_we",   64'(mem_we),   64'(e_we));
         chk("mem_addr", 64'(mem_addr), 64'(e_addr));
         chk("mem_din",  mem_din,       e_din);
      end
   end

   // small-config event log used by the literal checks
   int          ncyc = 0, wr_cnt = 0, done_t = 0;
   int          wr_t [8];
   logic [63:0] row1;
   always @(negedge clk) begin
      ncyc++;
      if (mem_we === 1'b1) begin
         if (wr_cnt < 8) wr_t[wr_cnt] = ncyc;
         wr_cnt++;
         if (mem_addr == 9'd1) row1 = mem_din;
      end
      if (done === 1'b1) done_t = ncyc;
   end

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic drive_frame(input int base, input bit toggle, input int bad_k, input int start_k, input int nbeats);
      int r, b, guard;
      for (int k = 0; k < nbeats; k++) begin
         r = k / SBEATS;
         b = k % SBEATS;
         if (toggle) begin
            s_valid = 1'b0;
            tick();
         end
         s_valid = 1'b1;
         s_last  = (b == SBEATS - 1) ^ (k == bad_k);
         start   = (k == start_k);
         for (int i = 0; i < SB; i++) s_data[8*i +: 8] = 8'(base + r * 8 + b * SB + i);
         guard = 0;
         @(negedge clk);
         while (s_ready !== 1'b1 && guard < 20) begin
            guard++;
            @(negedge clk);
         end
         if (s_ready !== 1'b1) begin
            n_total++; n_bad++;
            $display("FAIL ready_timeout beat=%0d got=%b exp=1", k, s_ready);
         end
         tick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      start   = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int guard;
      guard = 0;
      @(negedge clk);
      while (done !== 1'b1 && guard < 40) begin
         guard++;
         @(negedge clk);
      end
      if (done !== 1'b1) begin
         n_total++; n_bad++;
         $display("FAIL %s_done_timeout got=%b exp=1", name, done);
      end
      tick();
   endtask

   // ---------------- full-size frame checks ----------------
   bit d_final = 1'b0;
   bit full_fin = 1'b0;
   int d_ncyc = 0, d_wcnt = 0, d_last_addr = -1, d_prev_wt = 0, d_fin_t = -100, d_done_t = -1;
   logic [5119:0] d_exp;

   // full-size write log: address order, spacing and row contents
   always @(negedge clk) begin
      d_ncyc++;
      if (d_valid && d_ready === 1'b1 && d_final) d_fin_t = d_ncyc;
      if (d_we === 1'b1) begin
         chk("full_addr", 64'(d_addr), 64'(d_wcnt));
         if (d_wcnt > 0) chk("full_gap", 64'(d_ncyc - d_prev_wt), 64'(DBEATS));
         d_exp = drow(d_wcnt);
         n_total++;
         if (d_din !== d_exp) begin
            n_bad++;
            for (int c = 0; c < DC; c++) begin
               if (d_din[8*c +: 8] !== d_exp[8*c +: 8]) begin
                  $display("FAIL full_din row=%0d col=%0d got=%h exp=%h", d_wcnt, c, d_din[8*c +: 8], d_exp[8*c +: 8]);
                  break;
               end
            end
         end
         d_prev_wt = d_ncyc;
         d_last_addr = int'(d_addr);
         d_wcnt++;
      end
      if (d_done === 1'b1) d_done_t = d_ncyc;
   end

   // full-size stream driver, runs alongside the small-config sequence
   initial begin
      int r, b, guard;
      bit stop;
      d_rst = 1'b1; d_start = 1'b0; d_valid = 1'b0; d_last = 1'b0; d_data = '0;
      stop = 1'b0;
      repeat (3) tick();
      d_rst = 1'b0;
      d_start = 1'b1;
      tick();
      d_start = 1'b0;
      for (int k = 0; k < DR * DBEATS && !stop; k++) begin
         r = k / DBEATS;
         b = k % DBEATS;
         d_valid = 1'b1;
         d_last  = (b == DBEATS - 1);
         d_final = (k == DR * DBEATS - 1);
         for (int i = 0; i < 4; i++) d_data[8*i +: 8] = dpix(r, b * 4 + i);
         guard = 0;
         @(negedge clk);
         while (d_ready !== 1'b1 && guard < 20) begin
            guard++;
            @(negedge clk);
         end
         if (d_ready !== 1'b1) begin
            n_total++; n_bad++;
            $display("FAIL full_ready_timeout beat=%0d got=%b exp=1", k, d_ready);
            stop = 1'b1;
         end
         tick();
      end
      d_valid = 1'b0;
      d_last  = 1'b0;
      d_final = 1'b0;
      repeat (4) tick();
      chk("full_writes",    64'(d_wcnt),             64'd480);
      chk("full_last_addr", 64'(d_last_addr),        64'd479);
      chk("full_done_lat",  64'(d_done_t - d_fin_t), 64'd2);
      chk("full_err",       64'(d_err),              64'd0);
      chk("full_busy_end",  64'(d_busy),             64'd0);
      full_fin = 1'b1;
   end

   // small-config directed sequence and final summary
   initial begin
      int guard;
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
      row1 = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_busy",   64'(busy),     64'd0);
      chk("rst_done",   64'(done),     64'd0);
      chk("rst_ready",  64'(s_ready),  64'd0);
      chk("rst_we",     64'(mem_we),   64'd0);
      chk("rst_addr",   64'(mem_addr), 64'd0);
      chk("rst_din",    mem_din,       64'd0);

      // back-to-back frame
      wr_cnt = 0;
      do_start();
      drive_frame(0, 1'b0, -1, -1, SR * SBEATS);
      wait_done("t1");
      chk("t1_writes",   64'(wr_cnt),            64'd3);
      chk("t1_gap01",    64'(wr_t[1] - wr_t[0]), 64'd2);
      chk("t1_gap12",    64'(wr_t[2] - wr_t[1]), 64'd2);
      chk("t1_row1",     row1,                   64'h0F0E0D0C0B0A0908);
      chk("t1_done_lat", 64'(done_t - wr_t[2]),  64'd1);
      chk("t1_err",      64'(err),               64'd0);

      // s_valid toggling every cycle
      wr_cnt = 0; row1 = '0;
      do_start();
      drive_frame(0, 1'b1, -1, -1, SR * SBEATS);
      wait_done("t2");
      chk("t2_writes", 64'(wr_cnt),            64'd3);
      chk("t2_gap01",  64'(wr_t[1] - wr_t[0]), 64'd4);
      chk("t2_gap12",  64'(wr_t[2] - wr_t[1]), 64'd4);
      chk("t2_row1",   row1,                   64'h0F0E0D0C0B0A0908);

      // framing error on beat 0 of row 1
      wr_cnt = 0; row1 = '0;
      do_start();
      drive_frame(0, 1'b0, 2, -1, SR * SBEATS);
      wait_done("t3");
      chk("t3_err",    64'(err),    64'd1);
      chk("t3_writes", 64'(wr_cnt), 64'd3);
      chk("t3_row1",   row1,        64'h0F0E0D0C0B0A0908);
      do_start();
      chk("t3_err_clear", 64'(err), 64'd0);
      drive_frame(0, 1'b0, -1, -1, SR * SBEATS);
      wait_done("t3b");

      // reset mid-frame after the row-0 write
      wr_cnt = 0; row1 = '0;
      do_start();
      drive_frame(0, 1'b0, -1, -1, 2);
      rst = 1'b1; s_valid = 1'b1; s_last = 1'b0; s_data = 32'h0B0A0908;
      tick();
      rst = 1'b0;
      chk("t4_busy",  64'(busy),     64'd0);
      chk("t4_we",    64'(mem_we),   64'd0);
      chk("t4_addr",  64'(mem_addr), 64'd0);
      chk("t4_din",   mem_din,       64'd0);
      chk("t4_ready", 64'(s_ready),  64'd0);
      repeat (3) tick();
      s_valid = 1'b0;
      chk("t4_abandoned_writes", 64'(wr_cnt), 64'd1);
      wr_cnt = 0;
      do_start();
      drive_frame(8'h80, 1'b0, -1, -1, SR * SBEATS);
      wait_done("t4");
      chk("t4_writes", 64'(wr_cnt),  64'd3);
      chk("t4_first",  64'(wr_t[0] < wr_t[1]), 64'd1);
      chk("t4_row1",   row1,         64'h8F8E8D8C8B8A8988);

      // start pulses in LOAD and DONE, beats offered in IDLE
      wr_cnt = 0;
      do_start();
      drive_frame(0, 1'b0, -1, 1, SR * SBEATS);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t5_busy_after_done", 64'(busy), 64'd0);
      s_valid = 1'b1;
      chk("t5_idle_ready", 64'(s_ready), 64'd0);
      repeat (2) tick();
      s_valid = 1'b0;
      chk("t5_writes", 64'(wr_cnt), 64'd3);
      chk("t5_idle_busy", 64'(busy), 64'd0);

      guard = 0;
      while (!full_fin && guard < 90000) begin
         guard++;
         tick();
      end
      if (!full_fin) begin
         n_total++; n_bad++;
         $display("FAIL full_timeout got=0 exp=1");
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
